// File: rtl/counter_step_checker.sv
`default_nettype none
// ============================================================================
//  counter_step_checker
//  Predicts each next Q/RCO of the 4-bit mode counter from the previous sample,
//  flags mismatches, counts errors and wraps, and measures the RCO period.
//  Revision: 1.0
// ============================================================================
module counter_step_checker #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 16,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             enb,
   input  logic [1:0]       modo,
   input  logic [WIDTH-1:0] D,
   input  logic [WIDTH-1:0] Q,
   input  logic             RCO,
   output logic             step_err,
   output logic             rco_err,
   output logic             fault,
   output logic [ERR_W-1:0] err_count,
   output logic [CNT_W-1:0] wrap_count,
   output logic [CNT_W-1:0] period,
   output logic             period_valid
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      TRACK = 2'd2,
      FAULT = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_d;
   logic [1:0]       r_modo;
   logic             r_enb;

   logic             r_step_err;
   logic             r_rco_err;
   logic [ERR_W-1:0] r_err_count;
   logic [CNT_W-1:0] r_wrap_count;
   logic [CNT_W-1:0] r_period;
   logic             r_period_valid;
   logic [CNT_W-1:0] r_cyc;
   logic             r_armed;

   logic [WIDTH-1:0] w_pred_q;
   logic             w_pred_rco;
   logic             w_cmp;
   logic             w_step_bad;
   logic             w_rco_bad;
   logic [ERR_W:0]   w_err_sum;
   logic [ERR_W-1:0] w_err_nxt;

   // Expected counter response to the previously captured sample
   always_comb begin
      w_pred_q   = r_q;
      w_pred_rco = 1'b0;
      if (r_enb) begin
         case (r_modo)
            2'b00: begin
               w_pred_q   = r_q + WIDTH'(1);
               w_pred_rco = (r_q == '1);
            end
            2'b01: begin
               w_pred_q   = r_q - WIDTH'(1);
               w_pred_rco = (r_q == '0);
            end
            2'b10: begin
               w_pred_q   = r_q - WIDTH'(3);
               w_pred_rco = (r_q < WIDTH'(3));
            end
            default: begin
               w_pred_q   = r_d;
               w_pred_rco = 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      w_cmp      = (r_state == TRACK) || (r_state == FAULT);
      w_step_bad = w_cmp && (Q != w_pred_q);
      w_rco_bad  = w_cmp && (RCO != w_pred_rco);
      // One guard bit is enough: the largest sum is max + 2
      w_err_sum  = {1'b0, r_err_count} + (ERR_W+1)'(w_step_bad) + (ERR_W+1)'(w_rco_bad);
      w_err_nxt  = w_err_sum[ERR_W] ? '1 : w_err_sum[ERR_W-1:0];
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    w_state_nxt = PRIME;
         PRIME:   w_state_nxt = TRACK;
         TRACK:   if (w_step_bad || w_rco_bad) w_state_nxt = FAULT;
         default: w_state_nxt = FAULT;
      endcase
   end

   always_ff @(posedge clk) begin
      r_q    <= Q;
      r_d    <= D;
      r_modo <= modo;
      r_enb  <= enb;
   end

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         r_state        <= IDLE;
         r_step_err     <= 1'b0;
         r_rco_err      <= 1'b0;
         r_err_count    <= '0;
         r_wrap_count   <= '0;
         r_period       <= '0;
         r_period_valid <= 1'b0;
         r_cyc          <= '0;
         r_armed        <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_step_err     <= w_step_bad;
         r_rco_err      <= w_rco_bad;
         r_err_count    <= w_err_nxt;
         r_period_valid <= 1'b0;
         if (w_cmp) begin
            if (RCO) begin
               r_wrap_count <= r_wrap_count + CNT_W'(1);
               r_cyc        <= '0;
               r_armed      <= 1'b1;
               if (r_armed) begin
                  r_period       <= (r_cyc == '1) ? r_cyc : r_cyc + CNT_W'(1);
                  r_period_valid <= 1'b1;
               end
            end else if (r_cyc != '1) begin
               r_cyc <= r_cyc + CNT_W'(1);
            end
         end
      end
   end

   assign step_err     = r_step_err;
   assign rco_err      = r_rco_err;
   assign fault        = (r_state == FAULT);
   assign err_count    = r_err_count;
   assign wrap_count   = r_wrap_count;
   assign period       = r_period;
   assign period_valid = r_period_valid;

endmodule
`default_nettype wire
